// File: rtl/ttt_board_ctrl_pkg.sv
// Shared tic-tac-toe encodings: cell marks, winner codes, FSM states and the 8 line triples.
// The line table is also consumed by the pixel colour generator to highlight win_line.
package ttt_board_ctrl_pkg;

  localparam int NUM_CELLS = 9;
  localparam int NUM_LINES = 8;

  localparam logic [1:0] CELL_EMPTY = 2'd0;
  localparam logic [1:0] CELL_O     = 2'd1;
  localparam logic [1:0] CELL_X     = 2'd2;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_O    = 2'd1;
  localparam logic [1:0] WIN_X    = 2'd2;
  localparam logic [1:0] WIN_DRAW = 2'd3;

  localparam logic [3:0] MAX_MOVES = 4'd9;

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_EVAL = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  // Cell i (0-based) holds the mark of board position i+1, row-major.
  typedef logic [NUM_CELLS-1:0][1:0] board_t;

  // Line order matches win_line bit order: rows 1-3, cols 1-3, diag 1-5-9, diag 3-5-7.
  localparam int LINE_IDX [NUM_LINES][3] = '{
    '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
    '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
    '{0, 4, 8}, '{2, 4, 6}
  };

  function automatic logic [1:0] next_mark(input logic [1:0] mark);
    return (mark == CELL_O) ? CELL_X : CELL_O;
  endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Purpose: flags every completed line on a 9-cell board and reports the completing mark.
// Latency: combinational. Backpressure: none, pure function of the board.
module ttt_line_check
  import ttt_board_ctrl_pkg::*;
(
  input  board_t                 cells,
  output logic [NUM_LINES-1:0]   line_mask,
  output logic [1:0]             win_mark
);

  always_comb begin
    line_mask = '0;
    win_mark  = WIN_NONE;
    for (int l = 0; l < NUM_LINES; l++) begin
      if (cells[LINE_IDX[l][0]] != CELL_EMPTY &&
          cells[LINE_IDX[l][0]] == cells[LINE_IDX[l][1]] &&
          cells[LINE_IDX[l][1]] == cells[LINE_IDX[l][2]]) begin
        line_mask[l] = 1'b1;
        // Simultaneous lines always share the mark of the last mover.
        win_mark     = cells[LINE_IDX[l][0]];
      end
    end
  end

endmodule

// File: rtl/ttt_board_ctrl.sv
// Purpose: tic-tac-toe game state: board, turn, win/draw detection, freeze until new game.
// Latency: board 1 cycle after move strobe, winner 2 cycles. Backpressure: none, moves are acked or rejected.
module ttt_board_ctrl
  import ttt_board_ctrl_pkg::*;
#(
  parameter logic [1:0] FIRST_PLAYER = 2'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [3:0] move_cell,
  output logic [1:0] a1,
  output logic [1:0] a2,
  output logic [1:0] a3,
  output logic [1:0] a4,
  output logic [1:0] a5,
  output logic [1:0] a6,
  output logic [1:0] a7,
  output logic [1:0] a8,
  output logic [1:0] a9,
  output logic [1:0] turn,
  output logic [1:0] winner,
  output logic [7:0] win_line,
  output logic       move_ack,
  output logic       move_rej
);

  state_t                 state;
  board_t                 board;
  logic [3:0]             move_cnt;
  logic                   target_empty;
  logic [NUM_LINES-1:0]   line_mask;
  logic [1:0]             win_mark;

  assign a1 = board[0];
  assign a2 = board[1];
  assign a3 = board[2];
  assign a4 = board[3];
  assign a5 = board[4];
  assign a6 = board[5];
  assign a7 = board[6];
  assign a8 = board[7];
  assign a9 = board[8];

  // Out-of-range cells (0, 10..15) never match, so they read as occupied.
  always_comb begin
    target_empty = 1'b0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (move_cell == 4'(i + 1)) begin
        target_empty = (board[i] == CELL_EMPTY);
      end
    end
  end

  ttt_line_check u_line_check (
    .cells     (board),
    .line_mask (line_mask),
    .win_mark  (win_mark)
  );

  always_ff @(posedge clk) begin
    if (rst || new_game) begin
      state    <= ST_PLAY;
      board    <= '0;
      move_cnt <= '0;
      turn     <= FIRST_PLAYER;
      winner   <= WIN_NONE;
      win_line <= '0;
      move_ack <= 1'b0;
      move_rej <= 1'b0;
    end else begin
      move_ack <= 1'b0;
      move_rej <= 1'b0;
      case (state)
        ST_PLAY: begin
          if (move_valid) begin
            if (target_empty) begin
              for (int i = 0; i < NUM_CELLS; i++) begin
                if (move_cell == 4'(i + 1)) begin
                  board[i] <= turn;
                end
              end
              turn     <= next_mark(turn);
              move_cnt <= (move_cnt == MAX_MOVES) ? move_cnt : move_cnt + 4'd1;
              move_ack <= 1'b1;
              state    <= ST_EVAL;
            end else begin
              move_rej <= 1'b1;
            end
          end
        end
        ST_EVAL: begin
          move_rej <= move_valid;
          // A win on the ninth move outranks the draw.
          if (|line_mask) begin
            winner   <= win_mark;
            win_line <= line_mask;
            state    <= ST_OVER;
          end else if (move_cnt == MAX_MOVES) begin
            winner   <= WIN_DRAW;
            win_line <= '0;
            state    <= ST_OVER;
          end else begin
            state    <= ST_PLAY;
          end
        end
        ST_OVER: begin
          move_rej <= move_valid;
        end
        default: begin
          state <= ST_PLAY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ttt_board_ctrl.sv
// Directed bench for ttt_board_ctrl: win, double-win, X win, draw, illegal moves, new_game and reset priority.
module tb_ttt_board_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       new_game = 1'b0;
  logic       move_valid = 1'b0;
  logic [3:0] move_cell = 4'd0;
  logic [1:0] a1, a2, a3, a4, a5, a6, a7, a8, a9;
  logic [1:0] turn, winner;
  logic [7:0] win_line;
  logic       move_ack, move_rej;
  logic [17:0] board_v;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign board_v = {a9, a8, a7, a6, a5, a4, a3, a2, a1};

  ttt_board_ctrl #(.FIRST_PLAYER(2'd1)) dut (
    .clk        (clk),
    .rst        (rst),
    .new_game   (new_game),
    .move_valid (move_valid),
    .move_cell  (move_cell),
    .a1 (a1), .a2 (a2), .a3 (a3), .a4 (a4), .a5 (a5),
    .a6 (a6), .a7 (a7), .a8 (a8), .a9 (a9),
    .turn       (turn),
    .winner     (winner),
    .win_line   (win_line),
    .move_ack   (move_ack),
    .move_rej   (move_rej)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, sample just after the edge that consumes them.
  task automatic apply(input logic r, input logic g, input logic v, input logic [3:0] c);
    @(negedge clk);
    rst = r; new_game = g; move_valid = v; move_cell = c;
    @(posedge clk);
    #1;
    rst = 1'b0; new_game = 1'b0; move_valid = 1'b0; move_cell = 4'd0;
  endtask

  task automatic do_move(input logic [3:0] c);
    apply(1'b0, 1'b0, 1'b1, c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_board"},  32'(board_v),  32'h0);
    chk({tag, "_turn"},   32'(turn),     32'd1);
    chk({tag, "_winner"}, 32'(winner),   32'd0);
    chk({tag, "_line"},   32'(win_line), 32'h0);
    chk({tag, "_ack"},    32'(move_ack), 32'd0);
    chk({tag, "_rej"},    32'(move_rej), 32'd0);
  endtask

  initial begin
    apply(1'b1, 1'b0, 1'b0, 4'd0);
    chk_cleared("reset");

    // O takes the top row while X holds 4 and 5.
    do_move(4'd1);
    chk("g1_ack1", 32'(move_ack), 32'd1);
    chk("g1_rej1", 32'(move_rej), 32'd0);
    chk("g1_a1",   32'(a1),       32'd1);
    chk("g1_turn1", 32'(turn),    32'd2);
    tick();
    chk("g1_ack_pulse", 32'(move_ack), 32'd0);
    do_move(4'd4); tick();
    do_move(4'd2); tick();
    do_move(4'd5); tick();
    chk("g1_no_early_win", 32'(winner), 32'd0);
    do_move(4'd3);
    chk("g1_ack5",  32'(move_ack), 32'd1);
    chk("g1_board", 32'(board_v),  32'h295);
    chk("g1_winner_lag", 32'(winner), 32'd0);
    tick();
    chk("g1_winner", 32'(winner),   32'd1);
    chk("g1_line",   32'(win_line), 32'h01);
    do_move(4'd9);
    chk("over_rej",   32'(move_rej), 32'd1);
    chk("over_noack", 32'(move_ack), 32'd0);
    chk("over_board", 32'(board_v),  32'h295);
    tick();
    chk("over_rej_pulse", 32'(move_rej), 32'd0);
    chk("over_turn",      32'(turn),     32'd2);
    chk("over_line_held", 32'(win_line), 32'h01);

    // new_game outranks a simultaneous move: no ack, no rej, cell 7 stays empty.
    apply(1'b0, 1'b1, 1'b1, 4'd7);
    chk_cleared("ng_move");

    // Occupied target.
    do_move(4'd5);
    chk("dup_ack1", 32'(move_ack), 32'd1);
    tick();
    do_move(4'd5);
    chk("dup_rej",   32'(move_rej), 32'd1);
    chk("dup_noack", 32'(move_ack), 32'd0);
    chk("dup_board", 32'(board_v),  32'h100);
    chk("dup_turn",  32'(turn),     32'd2);
    tick();

    // Draw game, with EVAL-cycle and out-of-range rejects folded in.
    apply(1'b0, 1'b1, 1'b0, 4'd0);
    do_move(4'd1);
    do_move(4'd9);
    chk("eval_rej",   32'(move_rej), 32'd1);
    chk("eval_noack", 32'(move_ack), 32'd0);
    chk("eval_board", 32'(board_v),  32'h1);
    do_move(4'd0);
    chk("cell0_rej", 32'(move_rej), 32'd1);
    do_move(4'd12);
    chk("cell12_rej",   32'(move_rej), 32'd1);
    chk("bad_board",    32'(board_v),  32'h1);
    chk("bad_turn",     32'(turn),     32'd2);
    do_move(4'd2); tick();
    do_move(4'd3); tick();
    do_move(4'd5); tick();
    do_move(4'd4); tick();
    do_move(4'd6); tick();
    do_move(4'd8); tick();
    do_move(4'd7); tick();
    chk("draw_pending", 32'(winner), 32'd0);
    do_move(4'd9);
    chk("draw_ack9", 32'(move_ack), 32'd1);
    tick();
    chk("draw_winner", 32'(winner),   32'd3);
    chk("draw_line",   32'(win_line), 32'h0);
    chk("draw_board",  32'(board_v),  32'h16A59);
    do_move(4'd1);
    chk("draw_over_rej", 32'(move_rej), 32'd1);

    // O completes row 1 and column 1 at once on the ninth move.
    apply(1'b0, 1'b1, 1'b0, 4'd0);
    do_move(4'd2); tick();
    do_move(4'd5); tick();
    do_move(4'd3); tick();
    do_move(4'd6); tick();
    do_move(4'd4); tick();
    do_move(4'd8); tick();
    do_move(4'd7); tick();
    do_move(4'd9); tick();
    chk("dbl_pending", 32'(winner), 32'd0);
    do_move(4'd1); tick();
    chk("dbl_winner", 32'(winner),   32'd1);
    chk("dbl_line",   32'(win_line), 32'h09);

    // X wins on the 3-5-7 diagonal.
    apply(1'b0, 1'b1, 1'b0, 4'd0);
    do_move(4'd1); tick();
    do_move(4'd3); tick();
    do_move(4'd4); tick();
    do_move(4'd5); tick();
    do_move(4'd8); tick();
    do_move(4'd7); tick();
    chk("xwin_winner", 32'(winner),   32'd2);
    chk("xwin_line",   32'(win_line), 32'h80);

    // rst with new_game while a winning evaluation is pending.
    apply(1'b0, 1'b1, 1'b0, 4'd0);
    do_move(4'd1); tick();
    do_move(4'd4); tick();
    do_move(4'd2); tick();
    do_move(4'd5); tick();
    do_move(4'd3);
    chk("pend_ack", 32'(move_ack), 32'd1);
    apply(1'b1, 1'b1, 1'b0, 4'd0);
    chk_cleared("rst_eval");
    tick();
    chk("discard_winner", 32'(winner),   32'd0);
    chk("discard_line",   32'(win_line), 32'h0);
    do_move(4'd5);
    chk("post_rst_ack", 32'(move_ack), 32'd1);
    chk("post_rst_a5",  32'(a5),       32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
